// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the mips boot memory: loader FSM states,
// default image base address and byte-address to word-index conversion.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } boot_state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

  // Unsigned subtract; callers must separately reject addr < base.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mips_boot_mem_word_ram.sv
// depth x 32 word store: one write port, two registered read ports.
// Reads sample the array before the same-edge write lands (read-before-write).
module word_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_a_q;
  logic [31:0] rd_b_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rd_a_q <= mem_q[raddr_a];
    rd_b_q <= mem_q[raddr_b];
  end

  assign rdata_a = rd_a_q;
  assign rdata_b = rd_b_q;

endmodule

// File: rtl/mips_boot_mem.sv
// Boot memory for the mips core: streams a program image in over a valid/ready
// port while holding the core in reset, then serves fetches, loads and stores.
module mips_boot_mem
  import mips_mem_pkg::*;
#(
  parameter int          depth_words = 1024,
  parameter logic [31:0] base_addr   = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  // Load port: a beat transfers on a posedge where load_valid && load_ready.
  // load_ready is registered and does not depend on load_valid.
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        core_reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_rd_wr,
  output logic [31:0] data_in,
  output logic        load_err,
  output logic        access_err,
  output boot_state_t dbg_state
);

  localparam int          AW       = $clog2(depth_words);
  localparam logic [31:0] DEPTH32  = 32'(depth_words);
  localparam logic [AW:0] PTR_FULL = (AW + 1)'(depth_words);

  boot_state_t state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic        load_ready_q, load_ready_d;
  logic        core_reset_q, core_reset_d;
  logic        load_err_q, load_err_d;
  logic        access_err_q, access_err_d;
  logic        instr_ok_q, instr_ok_d;
  logic        data_ok_q, data_ok_d;

  logic [31:0] instr_idx, data_idx;
  logic        instr_oor, data_oor;
  logic        instr_bad, data_bad;
  logic        in_run, load_fire, ptr_full;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rd_a, ram_rd_b;

  always_comb begin
    instr_idx = word_index(instr_addr, base_addr);
    data_idx  = word_index(data_addr, base_addr);
    instr_oor = (instr_addr < base_addr) || (instr_idx >= DEPTH32);
    data_oor  = (data_addr < base_addr) || (data_idx >= DEPTH32);
    instr_bad = instr_oor || (instr_addr[1:0] != 2'b00);
    data_bad  = data_oor || (data_addr[1:0] != 2'b00);
  end

  assign in_run    = (state_q == RUN);
  assign load_fire = load_valid && load_ready_q;
  assign ptr_full  = (ptr_q == PTR_FULL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_fire) state_d = load_last ? RUN : LOAD;
      LOAD:    if (load_fire && load_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    ptr_d = ptr_q;
    if (load_fire && !ptr_full) begin
      ptr_d = ptr_q + 1'b1;
    end

    // Beats past the end of storage are still accepted so the image source
    // never stalls; they are dropped and flagged.
    load_err_d   = load_err_q || (load_fire && ptr_full);
    load_ready_d = (state_d != RUN);
    core_reset_d = (state_d != RUN);

    // The data address is checked every RUN cycle since a read's use is invisible here.
    access_err_d = access_err_q || (in_run && (instr_bad || data_bad));
    instr_ok_d   = in_run && !instr_oor;
    data_ok_d    = in_run && !data_oor;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ptr_q[AW-1:0];
    ram_wdata = load_data;
    if (in_run) begin
      ram_we    = !reset && !data_rd_wr && !data_oor;
      ram_waddr = data_idx[AW-1:0];
      ram_wdata = data_out;
    end else begin
      ram_we = !reset && load_fire && !ptr_full;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      load_ready_q <= 1'b0;
      core_reset_q <= 1'b1;
      load_err_q   <= 1'b0;
      access_err_q <= 1'b0;
      instr_ok_q   <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_ready_q <= load_ready_d;
      core_reset_q <= core_reset_d;
      load_err_q   <= load_err_d;
      access_err_q <= access_err_d;
      instr_ok_q   <= instr_ok_d;
      data_ok_q    <= data_ok_d;
    end
  end

  word_ram #(
    .DEPTH (depth_words),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (instr_idx[AW-1:0]),
    .rdata_a (ram_rd_a),
    .raddr_b (data_idx[AW-1:0]),
    .rdata_b (ram_rd_b)
  );

  // Out-of-range reads and cycles outside RUN present zero to the core.
  assign instr_in   = instr_ok_q ? ram_rd_a : 32'h0;
  assign data_in    = data_ok_q ? ram_rd_b : 32'h0;
  assign load_ready = load_ready_q;
  assign core_reset = core_reset_q;
  assign load_err   = load_err_q;
  assign access_err = access_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_boot_mem.sv
// Directed bench for mips_boot_mem: a full-size instance and a 4-word instance
// share the input stimulus; the small one exercises image overflow.
module tb_mips_boot_mem;
  import mips_mem_pkg::*;

  localparam logic [31:0] B = 32'h8002_0000;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic [31:0] instr_addr;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        data_rd_wr;

  logic        load_ready, core_reset, load_err, access_err;
  logic [31:0] instr_in, data_in;
  boot_state_t dbg_state;

  logic        s_load_ready, s_core_reset, s_load_err, s_access_err;
  logic [31:0] s_instr_in, s_data_in;
  boot_state_t s_dbg_state;

  int ntests = 0;
  int nfail  = 0;

  mips_boot_mem #(.depth_words(1024), .base_addr(B)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .core_reset (core_reset),
    .instr_addr (instr_addr),
    .instr_in   (instr_in),
    .data_addr  (data_addr),
    .data_out   (data_out),
    .data_rd_wr (data_rd_wr),
    .data_in    (data_in),
    .load_err   (load_err),
    .access_err (access_err),
    .dbg_state  (dbg_state)
  );

  mips_boot_mem #(.depth_words(4), .base_addr(B)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (s_load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .core_reset (s_core_reset),
    .instr_addr (instr_addr),
    .instr_in   (s_instr_in),
    .data_addr  (data_addr),
    .data_out   (data_out),
    .data_rd_wr (data_rd_wr),
    .data_in    (s_data_in),
    .load_err   (s_load_err),
    .access_err (s_access_err),
    .dbg_state  (s_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        rd_wr;
    logic [31:0] dout;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    logic        chk_d;
    logic        exp_aerr;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [31:0] ia, input logic [31:0] da,
                              input logic rw, input logic [31:0] dout,
                              input logic [31:0] ei, input logic [31:0] ed,
                              input logic cd, input logic ae);
    vec_t v;
    v.iaddr = ia; v.daddr = da; v.rd_wr = rw; v.dout = dout;
    v.exp_i = ei; v.exp_d = ed; v.chk_d = cd; v.exp_aerr = ae;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    logic accepted;
    accepted   = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    for (int c = 0; c < 20 && !accepted; c++) begin
      accepted = load_ready;
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("beat_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      instr_addr = vecs[k].iaddr;
      data_addr  = vecs[k].daddr;
      data_rd_wr = vecs[k].rd_wr;
      data_out   = vecs[k].dout;
      tick();
      check($sformatf("vec%0d_instr_in", k), instr_in, vecs[k].exp_i);
      if (vecs[k].chk_d) check($sformatf("vec%0d_data_in", k), data_in, vecs[k].exp_d);
      check($sformatf("vec%0d_access_err", k), 32'(access_err), 32'(vecs[k].exp_aerr));
    end
    data_rd_wr = 1'b1;
  endtask

  // stimulus and checks
  initial begin
    vecs[0]  = mk(B,          B + 32'h40,   1'b0, 32'h1234_5678, 32'h2402_0005, 32'h0,          1'b0, 1'b0);
    vecs[1]  = mk(B + 32'h40, B + 32'h40,   1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
    vecs[2]  = mk(B + 32'h40, B + 32'h40,   1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = vecs[2];
    vecs[6]  = mk(B + 32'h4,  B + 32'h40,   1'b1, 32'h0,         32'h2403_0007, 32'hDEAD_BEEF, 1'b1, 1'b0);
    vecs[7]  = mk(B + 32'h1000, B + 32'h1000, 1'b0, 32'h5555_5555, 32'h0,       32'h0,          1'b1, 1'b1);
    vecs[8]  = mk(B,          B,            1'b1, 32'h0,         32'h2402_0005, 32'h2402_0005, 1'b1, 1'b1);
    vecs[9]  = mk(B - 32'h4,  B + 32'hC,    1'b1, 32'h0,         32'h0,          32'hAC02_0000, 1'b1, 1'b1);
    vecs[10] = mk(B + 32'h6,  B + 32'h2,    1'b1, 32'h0,         32'h2403_0007, 32'h2402_0005, 1'b1, 1'b1);
    vecs[11] = mk(B,          B + 32'h10,   1'b0, 32'hCAFE_F00D, 32'h2402_0005, 32'h0,          1'b0, 1'b1);
    vecs[12] = mk(B + 32'h10, B + 32'h8,    1'b1, 32'h0,         32'hCAFE_F00D, 32'h0043_1021, 1'b1, 1'b1);
    vecs[13] = mk(B,          B + 32'h4,    1'b1, 32'h0,         32'hB000_0000, 32'hA000_0002, 1'b1, 1'b0);
    vecs[14] = mk(B + 32'h10, B + 32'h2,    1'b1, 32'h0,         32'hCAFE_F00D, 32'hB000_0000, 1'b1, 1'b1);

    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    load_last  = 1'b0;
    instr_addr = B;
    data_addr  = B;
    data_out   = 32'h0;
    data_rd_wr = 1'b1;

    // Reset values and a 4-word image
    do_reset(2);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_instr_in", instr_in, 32'h0);
    check("rst_data_in", data_in, 32'h0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_access_err", 32'(access_err), 32'd0);

    send_beat(32'h2402_0005, 1'b0);
    send_beat(32'h2403_0007, 1'b0);
    send_beat(32'h0043_1021, 1'b0);
    check("beat3_core_reset", 32'(core_reset), 32'd1);
    check("beat3_load_ready", 32'(load_ready), 32'd1);
    send_beat(32'hAC02_0000, 1'b1);
    check("last_load_ready", 32'(load_ready), 32'd0);
    check("last_core_reset", 32'(core_reset), 32'd0);
    check("last_state", 32'(dbg_state), 32'(RUN));
    check("last_load_err", 32'(load_err), 32'd0);

    // Fetch/load/store behaviour in RUN
    run_vecs(0, 12);

    // Mid-run reset, then a mid-load reset while the core tries to store
    do_reset(1);
    check("rerun_state", 32'(dbg_state), 32'(IDLE));
    check("rerun_instr_in", instr_in, 32'h0);
    check("rerun_access_err", 32'(access_err), 32'd0);
    check("rerun_core_reset", 32'(core_reset), 32'd1);

    instr_addr = B;
    data_addr  = B + 32'h10;
    data_out   = 32'h1111_1111;
    data_rd_wr = 1'b0;
    send_beat(32'hA000_0001, 1'b0);
    send_beat(32'hA000_0002, 1'b0);
    check("midload_state", 32'(dbg_state), 32'(LOAD));
    check("midload_core_reset", 32'(core_reset), 32'd1);
    check("midload_data_in", data_in, 32'h0);
    do_reset(1);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    check("midrst_load_ready", 32'(load_ready), 32'd0);
    send_beat(32'hB000_0000, 1'b1);
    check("reload_core_reset", 32'(core_reset), 32'd0);
    check("reload_state", 32'(dbg_state), 32'(RUN));
    data_rd_wr = 1'b1;
    run_vecs(13, 14);

    // Overflow on the 4-word instance
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      send_beat(32'hC000_0000 + 32'(k), (k == 5));
      if (k == 3) check("ovf_beat4_load_err", 32'(s_load_err), 32'd0);
      if (k == 4) begin
        check("ovf_beat5_load_err", 32'(s_load_err), 32'd1);
        check("ovf_beat5_load_ready", 32'(s_load_ready), 32'd1);
      end
    end
    check("ovf_state", 32'(s_dbg_state), 32'(RUN));
    check("ovf_load_ready", 32'(s_load_ready), 32'd0);
    check("ovf_core_reset", 32'(s_core_reset), 32'd0);
    check("ovf_load_err", 32'(s_load_err), 32'd1);
    check("big_no_load_err", 32'(load_err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      instr_addr = B + 32'(4 * k);
      data_addr  = B + 32'(4 * (3 - k));
      tick();
      check($sformatf("ovf_word%0d_instr", k), s_instr_in, 32'hC000_0000 + 32'(k));
      check($sformatf("ovf_word%0d_data", 3 - k), s_data_in, 32'hC000_0000 + 32'(3 - k));
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
